// File: rtl/accel_xtea_engine_pkg.sv
// Shared types and constants for the XTEA accelerator engine.
package accel_xtea_engine_pkg;

  localparam logic [31:0] XTEA_DELTA        = 32'h9E3779B9;
  localparam logic [31:0] XTEA_SUM_INIT_DEC = 32'hC6EF3720;

  // Engine FSM encoding kept as plain constants for legacy tooling.
  typedef logic [1:0] accel_state_e;
  localparam accel_state_e ACC_IDLE    = 2'd0;
  localparam accel_state_e ACC_CAPT_UH = 2'd1;
  localparam accel_state_e ACC_RUN     = 2'd2;

  typedef enum logic [1:0] {
    ACC_CMD_KEY,
    ACC_CMD_ENC,
    ACC_CMD_DEC
  } accel_cmd_e;

  // XTEA mixing function: ((x<<4) ^ (x>>5)) + x, mod 2^32.
  function automatic logic [31:0] xtea_f(input logic [31:0] x);
    return ((x << 4) ^ (x >> 5)) + x;
  endfunction

endpackage

// File: rtl/accel_xtea_engine_half_round.sv
// One XTEA half-round, purely combinational. v_a is the word being updated,
// v_b feeds the mixing function. dir: 0 = encrypt, 1 = decrypt.
module accel_xtea_half_round
  import accel_xtea_engine_pkg::*;
(
  input  logic [31:0]  v_a,
  input  logic [31:0]  v_b,
  input  logic [31:0]  sum,
  input  logic [127:0] key,
  input  logic         dir,
  input  logic         phase,
  output logic [31:0]  v_next,
  output logic [31:0]  sum_next
);

  logic        use_low;
  logic [31:0] sum_eff;
  logic [1:0]  k_idx;
  logic [31:0] k_word;
  logic [31:0] mix;

  // Key word pick, mix and sum update. The decrypt phase-1 decrement is applied
  // before the key lookup so it exactly inverts the encrypt phase-0 step.
  always_comb begin
    use_low = (phase == dir);
    sum_eff = (dir && phase) ? sum - XTEA_DELTA : sum;
    k_idx   = use_low ? sum_eff[1:0] : sum_eff[12:11];
    case (k_idx)
      2'd0:    k_word = key[127:96];
      2'd1:    k_word = key[95:64];
      2'd2:    k_word = key[63:32];
      default: k_word = key[31:0];
    endcase
    mix      = xtea_f(v_b) ^ (sum_eff + k_word);
    v_next   = dir ? v_a - mix : v_a + mix;
    sum_next = dir ? sum_eff : (phase ? sum : sum + XTEA_DELTA);
  end

endmodule

// File: rtl/accel_xtea_engine.sv
// XTEA accelerator responding to OPC_ACCEL strobes: serial operand capture,
// 128-bit key shift-in, and a one-half-round-per-clock encrypt/decrypt run.
module accel_xtea_engine
  import accel_xtea_engine_pkg::*;
#(
  parameter int NUM_CYCLES = 32,
  parameter int HALF_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_key_i,
  input  logic              start_enc_i,
  input  logic              start_dec_i,
  input  logic              op_first_i,
  input  logic [HALF_W-1:0] rs1_half_i,
  input  logic [HALF_W-1:0] rs2_half_i,
  input  logic [1:0]        res_sel_i,
  output logic [HALF_W-1:0] res_half_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              cmd_err_o
);

  localparam int          CW       = $clog2(2 * NUM_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * NUM_CYCLES - 1);
  localparam logic [31:0] SUM_DEC  = (NUM_CYCLES == 32) ? XTEA_SUM_INIT_DEC
                                                        : 32'(XTEA_DELTA * NUM_CYCLES);

  accel_state_e      state;
  accel_cmd_e        cmd;
  logic [HALF_W-1:0] lh1, lh2;
  logic [127:0]      key;
  logic [31:0]       v0, v1, sum;
  logic [CW-1:0]     cnt;
  logic              done, err;

  logic [2:0]        strb, exp_strb;
  accel_cmd_e        strb_cmd;
  logic [31:0]       rs1, rs2;
  logic              dir, upd_v0;
  logic [31:0]       v_a, v_b, v_next, sum_next;

  assign strb = {start_dec_i, start_enc_i, load_key_i};
  assign rs1  = {rs1_half_i, lh1};
  assign rs2  = {rs2_half_i, lh2};
  assign dir  = (cmd == ACC_CMD_DEC);
  // Encrypt updates v0 on phase 0, decrypt updates v1 on phase 0.
  assign upd_v0 = (cnt[0] == dir);
  assign v_a    = upd_v0 ? v0 : v1;
  assign v_b    = upd_v0 ? v1 : v0;

  // Strobe decode for the incoming command and the one expected on the UH cycle.
  always_comb begin
    strb_cmd = ACC_CMD_KEY;
    if (start_enc_i) strb_cmd = ACC_CMD_ENC;
    if (start_dec_i) strb_cmd = ACC_CMD_DEC;
    case (cmd)
      ACC_CMD_ENC: exp_strb = 3'b010;
      ACC_CMD_DEC: exp_strb = 3'b100;
      default:     exp_strb = 3'b001;
    endcase
  end

  accel_xtea_half_round u_half_round (
    .v_a      (v_a),
    .v_b      (v_b),
    .sum      (sum),
    .key      (key),
    .dir      (dir),
    .phase    (cnt[0]),
    .v_next   (v_next),
    .sum_next (sum_next)
  );

  // Command FSM, operand capture, key shift-in and round iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACC_IDLE;
      cmd   <= ACC_CMD_KEY;
      lh1   <= '0;
      lh2   <= '0;
      key   <= '0;
      v0    <= '0;
      v1    <= '0;
      sum   <= '0;
      cnt   <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        ACC_IDLE: begin
          if (|strb) begin
            if ($onehot(strb) && op_first_i) begin
              cmd   <= strb_cmd;
              lh1   <= rs1_half_i;
              lh2   <= rs2_half_i;
              done  <= 1'b0;
              err   <= 1'b0;
              state <= ACC_CAPT_UH;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ACC_CAPT_UH: begin
          if (strb == exp_strb && !op_first_i) begin
            if (cmd == ACC_CMD_KEY) begin
              key   <= {key[63:0], rs2, rs1};
              state <= ACC_IDLE;
            end else begin
              v0    <= rs1;
              v1    <= rs2;
              cnt   <= '0;
              sum   <= dir ? SUM_DEC : 32'd0;
              state <= ACC_RUN;
            end
          end else begin
            err   <= 1'b1;
            state <= ACC_IDLE;
          end
        end
        ACC_RUN: begin
          if (|strb) err <= 1'b1;
          if (upd_v0) v0 <= v_next;
          else        v1 <= v_next;
          sum <= sum_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            done  <= 1'b1;
            state <= ACC_IDLE;
          end
        end
        default: state <= ACC_IDLE;
      endcase
    end
  end

  assign busy_o    = (state == ACC_RUN);
  assign done_o    = done;
  assign cmd_err_o = err;

  // Result half read port, blanked while the block registers are in flux.
  always_comb begin
    res_half_o = '0;
    if (!busy_o) begin
      case (res_sel_i)
        2'd0:    res_half_o = v0[15:0];
        2'd1:    res_half_o = v0[31:16];
        2'd2:    res_half_o = v1[15:0];
        default: res_half_o = v1[31:16];
      endcase
    end
  end

endmodule

// File: tb/tb_accel_xtea_engine.sv
// Scoreboard bench for accel_xtea_engine: a plain XTEA reference predicts each
// block result when the command is issued; results are popped on completion.
module tb_accel_xtea_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_key_i = 1'b0, start_enc_i = 1'b0, start_dec_i = 1'b0, op_first_i = 1'b0;
  logic [15:0] rs1_half_i = '0, rs2_half_i = '0;
  logic [1:0]  res_sel_i = '0;
  logic [15:0] res_half_o;
  logic        busy_o, done_o, cmd_err_o;

  int          errs = 0;
  int          checks = 0;
  logic [63:0] exp_q[$];
  logic [127:0] key_m = '0;

  accel_xtea_engine #(.NUM_CYCLES(32), .HALF_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_key_i(load_key_i), .start_enc_i(start_enc_i), .start_dec_i(start_dec_i),
    .op_first_i(op_first_i), .rs1_half_i(rs1_half_i), .rs2_half_i(rs2_half_i),
    .res_sel_i(res_sel_i), .res_half_o(res_half_o),
    .busy_o(busy_o), .done_o(done_o), .cmd_err_o(cmd_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Reference XTEA, 32 cycles; k[0] is the most significant key word.
  function automatic logic [63:0] golden(input bit dec, input logic [127:0] key,
                                         input logic [63:0] blk);
    logic [31:0] k[4];
    logic [31:0] v0, v1, sum;
    k[0] = key[127:96]; k[1] = key[95:64]; k[2] = key[63:32]; k[3] = key[31:0];
    v0 = blk[63:32];
    v1 = blk[31:0];
    if (!dec) begin
      sum = 32'd0;
      for (int i = 0; i < 32; i++) begin
        v0  += (((v1 << 4) ^ (v1 >> 5)) + v1) ^ (sum + k[sum[1:0]]);
        sum += 32'h9E3779B9;
        v1  += (((v0 << 4) ^ (v0 >> 5)) + v0) ^ (sum + k[sum[12:11]]);
      end
    end else begin
      sum = 32'hC6EF3720;
      for (int i = 0; i < 32; i++) begin
        v1  -= (((v0 << 4) ^ (v0 >> 5)) + v0) ^ (sum + k[sum[12:11]]);
        sum -= 32'h9E3779B9;
        v0  -= (((v1 << 4) ^ (v1 >> 5)) + v1) ^ (sum + k[sum[1:0]]);
      end
    end
    return {v0, v1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two-cycle command: LH then UH. c: 0 key, 1 enc, 2 dec.
  task automatic issue(input int c, input logic [31:0] a, input logic [31:0] b);
    load_key_i  = (c == 0);
    start_enc_i = (c == 1);
    start_dec_i = (c == 2);
    op_first_i  = 1'b1;
    rs1_half_i  = a[15:0];
    rs2_half_i  = b[15:0];
    tick();
    op_first_i  = 1'b0;
    rs1_half_i  = a[31:16];
    rs2_half_i  = b[31:16];
    tick();
    load_key_i = 1'b0; start_enc_i = 1'b0; start_dec_i = 1'b0;
  endtask

  task automatic load_key(input logic [31:0] a, input logic [31:0] b);
    key_m = {key_m[63:0], b, a};
    issue(0, a, b);
  endtask

  task automatic read_res(output logic [63:0] r);
    logic [15:0] h[4];
    for (int s = 0; s < 4; s++) begin
      res_sel_i = 2'(s);
      #1;
      h[s] = res_half_o;
    end
    r = {h[1], h[0], h[3], h[2]};
    @(posedge clk);
    #1;
  endtask

  // Run one block; inj >= 0 drives a stray ST_ENC at that RUN cycle.
  task automatic run_blk(input bit dec, input logic [63:0] blk, input int inj,
                         output logic [63:0] r);
    int n;
    exp_q.push_back(golden(dec, key_m, blk));
    issue(dec ? 2 : 1, blk[63:32], blk[31:0]);
    chk("accept_done_clr", done_o, 0);
    chk("accept_err_clr", cmd_err_o, 0);
    n = 0;
    while (busy_o && n < 200) begin
      if (n == 5) chk("busy_res_zero", res_half_o, 0);
      if (n == inj) begin start_enc_i = 1'b1; op_first_i = 1'b1; end
      tick();
      if (n == inj) begin
        start_enc_i = 1'b0; op_first_i = 1'b0;
        chk("run_strobe_err", cmd_err_o, 1);
        chk("run_strobe_busy", busy_o, 1);
      end
      n++;
    end
    chk("busy_len", n, 64);
    chk("done_set", done_o, 1);
    read_res(r);
    if (exp_q.size() > 0) chk("sb_blk", r, exp_q.pop_front());
    else chk("sb_empty", exp_q.size(), 1);
  endtask

  initial begin
    #500000;
    errs++;
    $display("FAIL watchdog: sim time exceeded");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r, ct, pt;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", cmd_err_o, 0);
    chk("rst_res", res_half_o, 0);
    rst_n = 1'b1;
    tick();

    // Zero key, zero block: known answer, then decrypt back to zero.
    load_key(32'h0, 32'h0);
    load_key(32'h0, 32'h0);
    run_blk(0, 64'h0, -1, r);
    chk("t1_kat", r, 64'hDEE9D4D8_F7131ED9);
    run_blk(1, r, -1, r);
    chk("t2_h0", r[47:32], 0);
    chk("t2_h1", r[63:48], 0);
    chk("t2_h2", r[15:0], 0);
    chk("t2_h3", r[31:16], 0);

    // Byte-pattern key, random blocks with round-trip.
    load_key(32'h04050607, 32'h00010203);
    load_key(32'h0C0D0E0F, 32'h08090A0B);
    chk("key_model", key_m, 128'h00010203_04050607_08090A0B_0C0D0E0F);
    for (int i = 0; i < 3; i++) begin
      pt = {$urandom, $urandom};
      run_blk(0, pt, -1, ct);
      run_blk(1, ct, -1, r);
      chk("t3_roundtrip", r, pt);
    end

    // Stray strobe during RUN: flagged, result unaffected, then cleared.
    run_blk(0, {$urandom, $urandom}, 10, r);
    run_blk(0, {$urandom, $urandom}, -1, r);

    // Multiple strobes at once.
    load_key_i = 1'b1; start_enc_i = 1'b1; op_first_i = 1'b1;
    tick();
    load_key_i = 1'b0; start_enc_i = 1'b0; op_first_i = 1'b0;
    chk("t5_multi_err", cmd_err_o, 1);
    chk("t5_multi_busy", busy_o, 0);
    run_blk(0, {$urandom, $urandom}, -1, r);
    // UH without LH.
    start_dec_i = 1'b1; op_first_i = 1'b0;
    tick();
    start_dec_i = 1'b0;
    chk("t5_uh_only_err", cmd_err_o, 1);
    chk("t5_uh_only_busy", busy_o, 0);
    run_blk(0, {$urandom, $urandom}, -1, r);
    // LH of LD_KEY with the UH cycle missing: abort, key untouched.
    load_key_i = 1'b1; op_first_i = 1'b1; rs1_half_i = 16'hAAAA; rs2_half_i = 16'h5555;
    tick();
    load_key_i = 1'b0; op_first_i = 1'b0;
    tick();
    chk("t5_abort_err", cmd_err_o, 1);
    chk("t5_abort_busy", busy_o, 0);
    run_blk(0, {$urandom, $urandom}, -1, r);

    // Reset in the middle of a run.
    issue(1, $urandom, $urandom);
    repeat (30) tick();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy_o, 0);
    chk("t6_rst_done", done_o, 0);
    chk("t6_rst_res", res_half_o, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    key_m = '0;
    exp_q.delete();
    tick();
    run_blk(0, 64'h0, -1, r);
    chk("t6_key_lost_kat", r, 64'hDEE9D4D8_F7131ED9);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
